// File: rtl/trig_pkg.sv
// Shared constants and FSM encoding for the trigger burst scheduler.
// The period floor leaves room for the trigger generator's pulse width.
package trig_pkg;

    localparam int TRIG_EN_HIGH    = 2;
    localparam int TRIG_MIN_PERIOD = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_FIRE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/trig_interval_cnt.sv
// Loadable down-counter shared by the delay, fire and gap phases.
// Holds at zero; o_zero comes straight from the count register.
module trig_interval_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_val;
        end else if (i_en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign o_zero = (cnt == '0);

endmodule

// File: rtl/trig_burst_scheduler.sv
// Start-delay / fixed-period / burst-length sequencer for the trigger
// generator enable. All outputs are registered from the next state.
module trig_burst_scheduler
    import trig_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter int EN_HIGH    = TRIG_EN_HIGH,
    parameter int MIN_PERIOD = TRIG_MIN_PERIOD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [CNT_W-1:0]   i_delay,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic [BURST_W-1:0] o_pulse_cnt
);

    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(EN_HIGH - 1);
    localparam logic [CNT_W-1:0] GAP_SUB = CNT_W'(EN_HIGH + 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]   period_q;
    logic [BURST_W-1:0] burst_q;
    logic               stop_pend;

    logic               cnt_load;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;

    logic               accept;
    logic               abort;
    logic               pulse;
    logic               last;

    trig_interval_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (cnt_load),
        .i_en   (cnt_en),
        .i_val  (cnt_val),
        .o_zero (cnt_zero)
    );

    assign last = (burst_q != '0) && (o_pulse_cnt == burst_q);

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_val   = '0;
        accept    = 1'b0;
        abort     = 1'b0;
        pulse     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_nxt = ST_DELAY;
                    accept    = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = i_delay;
                end
            end
            ST_DELAY: begin
                if (i_stop) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_FIRE;
                    cnt_load  = 1'b1;
                    cnt_val   = HI_LOAD;
                    pulse     = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_FIRE: begin
                // A stop seen mid-pulse waits for the full high time
                if (cnt_zero) begin
                    if (i_stop || stop_pend) begin
                        state_nxt = ST_DONE;
                        abort     = 1'b1;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_load  = 1'b1;
                        cnt_val   = period_q - GAP_SUB;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (i_stop) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end else if (cnt_zero) begin
                    if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FIRE;
                        cnt_load  = 1'b1;
                        cnt_val   = HI_LOAD;
                        pulse     = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            period_q    <= '0;
            burst_q     <= '0;
            stop_pend   <= 1'b0;
            o_en        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_aborted   <= 1'b0;
            o_pulse_cnt <= '0;
        end else begin
            state  <= state_nxt;
            o_en   <= (state_nxt == ST_FIRE);
            o_busy <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            o_done <= (state_nxt == ST_DONE);
            if (accept) begin
                period_q    <= (i_period < MIN_P) ? MIN_P : i_period;
                burst_q     <= i_burst_len;
                stop_pend   <= 1'b0;
                o_aborted   <= 1'b0;
                o_pulse_cnt <= '0;
            end else begin
                if ((state == ST_FIRE) && i_stop) begin
                    stop_pend <= 1'b1;
                end
                if (abort) begin
                    o_aborted <= 1'b1;
                end
                if (pulse && (o_pulse_cnt != '1)) begin
                    o_pulse_cnt <= o_pulse_cnt + BURST_W'(1);
                end
            end
        end
    end

endmodule
